// File: rtl/array_prod_mac.sv
// Sequential fixed-point dot product: one signed MAC per clock over N packed elements,
// then the accumulator is rescaled by QM, saturated to BW bits and held with dataReady.
module array_prod_mac #(
  parameter int N  = 8,
  parameter int QN = 6,
  parameter int QM = 11
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [N*(QN+QM+1)-1:0] inputA,
  input  logic [N*(QN+QM+1)-1:0] inputB,
  output logic                   dataReady,
  output logic [QN+QM:0]         outputVal
);

  localparam int BW = QN + QM + 1;
  localparam int IW = $clog2(N + 1);
  localparam int AW = 2 * BW + IW;

  // Rails expressed at accumulator width so the clamp compares like with like
  localparam logic signed [AW-1:0] SAT_MAX = {{(AW-BW+1){1'b0}}, {(BW-1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_MIN = {{(AW-BW+1){1'b1}}, {(BW-1){1'b0}}};

  typedef enum logic {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } state_t;

  state_t                 state;
  state_t                 next_state;
  logic [IW-1:0]          idx;
  logic signed [AW-1:0]   acc;
  logic signed [BW-1:0]   a_sel;
  logic signed [BW-1:0]   b_sel;
  logic signed [2*BW-1:0] product;
  logic signed [AW-1:0]   shifted;
  logic [BW-1:0]          sat_val;
  logic                   do_mac;
  logic                   do_finish;

  always_comb begin
    next_state = state;
    a_sel      = '0;
    b_sel      = '0;
    do_mac     = 1'b0;
    do_finish  = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (idx == IW'(i)) begin
        a_sel = inputA[i*BW +: BW];
        b_sel = inputB[i*BW +: BW];
      end
    end
    case (state)
      ACCUM: begin
        if (idx == IW'(N)) begin
          do_finish  = 1'b1;
          next_state = DONE;
        end else begin
          do_mac = 1'b1;
        end
      end
      DONE:    next_state = DONE;
      default: next_state = ACCUM;
    endcase
  end

  // Arithmetic shift floors toward -inf; no rounding is applied
  always_comb begin
    product = a_sel * b_sel;
    shifted = acc >>> QM;
    if (shifted > SAT_MAX) begin
      sat_val = SAT_MAX[BW-1:0];
    end else if (shifted < SAT_MIN) begin
      sat_val = SAT_MIN[BW-1:0];
    end else begin
      sat_val = shifted[BW-1:0];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= ACCUM;
    end else begin
      state <= next_state;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      idx       <= '0;
      acc       <= '0;
      dataReady <= 1'b0;
      outputVal <= '0;
    end else if (do_mac) begin
      acc <= acc + {{(AW-2*BW){product[2*BW-1]}}, product};
      idx <= idx + 1'b1;
    end else if (do_finish) begin
      outputVal <= sat_val;
      dataReady <= 1'b1;
    end
  end

endmodule

// File: tb/tb_array_prod_mac.sv
// Self-checking bench for array_prod_mac: fixed corner vectors plus random vectors scored
// against an integer dot-product model, and hand sequences for reset, mid-run and hold behaviour.
module tb_array_prod_mac;

  localparam int N  = 8;
  localparam int QN = 6;
  localparam int QM = 11;
  localparam int BW = QN + QM + 1;
  localparam int NUM_FIXED  = 6;
  localparam int NUM_RANDOM = 20;
  localparam int NUM_VEC    = NUM_FIXED + NUM_RANDOM;

  typedef struct {
    logic [N*BW-1:0] a;
    logic [N*BW-1:0] b;
    logic [BW-1:0]   expected;
    string           name;
  } vec_t;

  logic            clock;
  logic            reset;
  logic [N*BW-1:0] inputA;
  logic [N*BW-1:0] inputB;
  logic            dataReady;
  logic [BW-1:0]   outputVal;

  int   vectors_applied;
  int   miscompares;
  vec_t table_vec [NUM_VEC];

  array_prod_mac #(.N(N), .QN(QN), .QM(QM)) dut (
    .clock     (clock),
    .reset     (reset),
    .inputA    (inputA),
    .inputB    (inputB),
    .dataReady (dataReady),
    .outputVal (outputVal)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [N*BW-1:0] splat(input logic [BW-1:0] v);
    logic [N*BW-1:0] r;
    for (int i = 0; i < N; i++) r[i*BW +: BW] = v;
    return r;
  endfunction

  // Reference: exact integer dot product, floor-divide by 2^QM, clamp to BW-bit signed range
  function automatic logic [BW-1:0] model(input logic [N*BW-1:0] a, input logic [N*BW-1:0] b);
    longint sum;
    longint ea;
    longint eb;
    longint lo;
    longint hi;
    logic [BW-1:0] ta;
    logic [BW-1:0] tb;
    sum = 0;
    for (int i = 0; i < N; i++) begin
      ta = a[i*BW +: BW];
      tb = b[i*BW +: BW];
      ea = longint'($signed(ta));
      eb = longint'($signed(tb));
      sum = sum + ea * eb;
    end
    sum = sum >>> QM;
    hi = (longint'(1) <<< (BW - 1)) - 1;
    lo = -(longint'(1) <<< (BW - 1));
    if (sum > hi) sum = hi;
    if (sum < lo) sum = lo;
    return sum[BW-1:0];
  endfunction

  task automatic checkOutput(input string name, input logic [BW-1:0] actual,
                             input logic [BW-1:0] expected);
    vectors_applied++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Asserts reset mid-cycle, checks the async clear, then releases on a falling edge
  task automatic resetAndLoad(input logic [N*BW-1:0] a, input logic [N*BW-1:0] b);
    @(negedge clock);
    reset  = 1'b0;
    inputA = a;
    inputB = b;
    #1;
    checkOutput("async_clear_ready", BW'(dataReady), '0);
    checkOutput("async_clear_value", outputVal, '0);
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic applyStimulus(input vec_t v);
    resetAndLoad(v.a, v.b);
    for (int e = 1; e <= N; e++) begin
      @(posedge clock);
      #1;
      checkOutput({v.name, "_busy_ready"}, BW'(dataReady), '0);
    end
    @(posedge clock);
    #1;
    checkOutput({v.name, "_done_ready"}, BW'(dataReady), BW'(1));
    checkOutput({v.name, "_result"}, outputVal, v.expected);
  endtask

  initial begin
    vectors_applied = 0;
    miscompares     = 0;
    reset  = 1'b0;
    inputA = '0;
    inputB = '0;

    table_vec[0] = '{splat(18'd2048), splat(18'd2048), 18'd16384, "ones"};
    table_vec[1] = '{splat(18'd1024), splat(18'h3F800), 18'h3E000, "half_neg"};
    table_vec[2] = '{splat(18'h1FFFF), splat(18'h1FFFF), 18'h1FFFF, "sat_pos"};
    table_vec[3] = '{splat(18'h1FFFF), splat(18'h20000), 18'h20000, "sat_neg"};
    table_vec[4] = '{(N*BW)'(18'd1), (N*BW)'(18'd1), 18'd0, "tiny_pos"};
    table_vec[5] = '{(N*BW)'(18'h3FFFF), (N*BW)'(18'd1), 18'h3FFFF, "tiny_floor"};
    for (int k = 0; k < NUM_RANDOM; k++) begin
      logic [N*BW-1:0] ra;
      logic [N*BW-1:0] rb;
      for (int i = 0; i < N; i++) begin
        if (k % 2 == 0) begin
          ra[i*BW +: BW] = BW'($urandom);
          rb[i*BW +: BW] = BW'($urandom);
        end else begin
          ra[i*BW +: BW] = BW'(int'($urandom_range(0, 8191)) - 4096);
          rb[i*BW +: BW] = BW'(int'($urandom_range(0, 8191)) - 4096);
        end
      end
      table_vec[NUM_FIXED + k] = '{ra, rb, model(ra, rb), $sformatf("rand%0d", k)};
    end

    #2;
    checkOutput("reset_ready", BW'(dataReady), '0);
    checkOutput("reset_value", outputVal, '0);

    for (int t = 0; t < NUM_VEC; t++) applyStimulus(table_vec[t]);

    // Abort after four MACs, then a fresh run must take exactly N+1 edges again
    resetAndLoad(splat(18'd2048), splat(18'd2048));
    repeat (4) @(posedge clock);
    #1;
    reset = 1'b0;
    #1;
    checkOutput("abort_ready", BW'(dataReady), '0);
    checkOutput("abort_value", outputVal, '0);
    applyStimulus(table_vec[0]);

    // Result stays put while inputs change after completion
    inputA = '0;
    inputB = '0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clock);
      #1;
      checkOutput("hold_ready", BW'(dataReady), BW'(1));
      checkOutput("hold_value", outputVal, 18'd16384);
    end

    // Changing B after four elements were consumed only zeroes the remaining products
    resetAndLoad(splat(18'd2048), splat(18'd2048));
    repeat (4) @(posedge clock);
    #1;
    inputB = '0;
    repeat (N - 4) @(posedge clock);
    #1;
    checkOutput("midrun_busy_ready", BW'(dataReady), '0);
    @(posedge clock);
    #1;
    checkOutput("midrun_done_ready", BW'(dataReady), BW'(1));
    checkOutput("midrun_value", outputVal, 18'd8192);

    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
    $finish;
  end

endmodule
